// File: rtl/accum_drain_ctrl_pkg.sv
// Shared constants and FSM state encoding for the accumulator drain controller.
package accum_drain_ctrl_pkg;

  localparam int LANES      = 64;
  localparam int DW         = 16;
  localparam int BEAT_W     = 256;
  localparam int CNT_W      = 16;
  localparam int VEC_W      = LANES * DW;
  localparam int BEATS      = VEC_W / BEAT_W;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_ACC   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/accum_beat_serializer.sv
// Holds a captured result vector and streams it out as fixed-width beats,
// lowest slice first, with a valid/ready handshake.
module accum_beat_serializer #(
  parameter int VW = 1024,
  parameter int BW = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic [VW-1:0] cap_data,
  input  logic          out_ready,
  output logic          out_v,
  output logic [BW-1:0] out_data,
  output logic          out_last,
  output logic          last_hs
);

  localparam int BEATS = VW / BW;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [VW-1:0]    snap_q, snap_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic             out_v_q, out_v_d;
  logic             hs;
  logic             last_beat;

  assign last_beat = (beat_q == IDX_W'(BEATS - 1));
  assign hs        = out_v_q & out_ready;

  // Capture loads the snapshot and restarts at beat 0; each handshake advances.
  always_comb begin
    snap_d  = snap_q;
    beat_d  = beat_q;
    out_v_d = out_v_q;
    if (capture) begin
      snap_d  = cap_data;
      beat_d  = '0;
      out_v_d = 1'b1;
    end else if (hs) begin
      if (last_beat) begin
        beat_d  = '0;
        out_v_d = 1'b0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Snapshot, beat index and valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q  <= '0;
      beat_q  <= '0;
      out_v_q <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      beat_q  <= beat_d;
      out_v_q <= out_v_d;
    end
  end

  assign out_v    = out_v_q;
  assign out_data = out_v_q ? snap_q[int'(beat_q) * BW +: BW] : '0;
  assign out_last = out_v_q & last_beat;
  assign last_hs  = hs & last_beat;

endmodule

// File: rtl/accum_drain_ctrl.sv
// Sequences one accumulation tile: clear the accumulator, feed cfg_len partial
// sum vectors through, count the accumulator responses, then drain the final
// result downstream as beats.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start with a nonzero length
// ST_CLR   | one-cycle accumulator clear
// ST_ACC   | forwarding upstream vectors, counting issues and responses
// ST_WAIT  | all vectors issued, waiting for remaining responses
// ST_DRAIN | serializer streaming the captured result
module accum_drain_ctrl #(
  parameter int LANES  = 64,
  parameter int DW     = 16,
  parameter int BEAT_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_len,
  input  logic                  in_v,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  in_ready,
  output logic                  acc_data_v,
  output logic [LANES*DW-1:0]   acc_data,
  output logic                  acc_usr_rst,
  input  logic                  acc_reg_v,
  input  logic [LANES*DW-1:0]   acc_reg,
  output logic                  out_v,
  input  logic                  out_ready,
  output logic [BEAT_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  import accum_drain_ctrl_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] resp_q, resp_d;
  logic             in_ready_q, in_ready_d;
  logic             done_q, done_d;
  logic             xfer;
  logic             resp_ev;
  logic             capture;
  logic             last_hs;

  assign xfer    = in_v & in_ready_q;
  // Responses only count once the clear has been issued and before draining.
  assign resp_ev = acc_reg_v & ((state_q == ST_ACC) || (state_q == ST_WAIT));

  // Next-state, counters and the capture strobe for the serializer.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    issue_d = issue_q;
    resp_d  = resp_q;
    capture = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (cfg_len != '0)) begin
          len_d   = cfg_len;
          issue_d = '0;
          resp_d  = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: state_d = ST_ACC;
      ST_ACC, ST_WAIT: begin
        if (xfer)    issue_d = issue_q + 1'b1;
        if (resp_ev) resp_d  = resp_q + 1'b1;
        // Final response wins over the final issue when both land together.
        if (resp_ev && ((resp_q + 1'b1) == len_q)) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end else if (xfer && ((issue_q + 1'b1) == len_q)) begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (last_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_ACC);
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issue_q    <= '0;
      resp_q     <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      resp_q     <= resp_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign acc_data_v  = xfer;
  assign acc_data    = in_data;
  assign acc_usr_rst = (state_q == ST_CLR);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

  accum_beat_serializer #(
    .VW (LANES * DW),
    .BW (BEAT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .cap_data  (acc_reg),
    .out_ready (out_ready),
    .out_v     (out_v),
    .out_data  (out_data),
    .out_last  (out_last),
    .last_hs   (last_hs)
  );

endmodule
